// File: rtl/cam_req_queue.sv
// -----------------------------------------------------------------------------
// cam_req_queue
//   Front-end stage in front of the cam block. Client read/write/search
//   requests are buffered in a small FIFO and issued to the cam one at a time,
//   so the cam never sees more than one strobe. Read and search results are
//   captured one cycle after the strobe and returned on a valid/ready channel.
//
// Ports
//   clk, reset_i            clock, synchronous active-high reset
//   req_*                   client request channel (valid/ready, op/index/data)
//                           op: 00 read, 01 write, 10 search, 11 reserved (dropped)
//   read_o/write_o/search_o cam strobes (at most one high, only in ISSUE)
//   *_index_o, *_data_o     cam index/data, zero outside ISSUE
//   read_valid_i, read_value_i, search_valid_i, search_index_i
//                           cam results, valid the cycle after the strobe
//   rsp_*                   response channel (read/search only)
//   stat_hits_o/stat_misses_o
//                           saturating response hit/miss counters, present
//                           only when CAM_REQ_STATS_EN is defined, else 0
//
// Optional feature macro: CAM_REQ_STATS_EN
// -----------------------------------------------------------------------------
module cam_req_queue #(
  parameter int ARRAY_WIDTH_LOG2 = 5,
  parameter int DEPTH_LOG2       = 2
) (
  input  logic                           clk,
  input  logic                           reset_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [1:0]                     req_op_i,
  input  logic [ARRAY_WIDTH_LOG2-1:0]    req_index_i,
  input  logic [2**ARRAY_WIDTH_LOG2-1:0] req_data_i,
  output logic                           read_o,
  output logic                           write_o,
  output logic                           search_o,
  output logic [ARRAY_WIDTH_LOG2-1:0]    read_index_o,
  output logic [ARRAY_WIDTH_LOG2-1:0]    write_index_o,
  output logic [2**ARRAY_WIDTH_LOG2-1:0] write_data_o,
  output logic [2**ARRAY_WIDTH_LOG2-1:0] search_data_o,
  input  logic                           read_valid_i,
  input  logic                           search_valid_i,
  input  logic [2**ARRAY_WIDTH_LOG2-1:0] read_value_i,
  input  logic [ARRAY_WIDTH_LOG2-1:0]    search_index_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [1:0]                     rsp_op_o,
  output logic                           rsp_hit_o,
  output logic [2**ARRAY_WIDTH_LOG2-1:0] rsp_data_o,
  output logic [15:0]                    stat_hits_o,
  output logic [15:0]                    stat_misses_o
);

  localparam int AW    = ARRAY_WIDTH_LOG2;
  localparam int DW    = 2**ARRAY_WIDTH_LOG2;
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and pointers (one extra wrap bit to tell full from empty)
  logic [1:0]           fifo_op_q   [DEPTH];
  logic [AW-1:0]        fifo_idx_q  [DEPTH];
  logic [DW-1:0]        fifo_data_q [DEPTH];
  logic [DEPTH_LOG2:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 fifo_empty, fifo_full, push;

  // Op register (current request) and response registers
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    rsp_op_q, rsp_op_d;
  logic          rsp_hit_q, rsp_hit_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  // Ready comes only from the registered pointers: a pop in the same cycle
  // does not open a slot for a push until the next cycle.
  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && !fifo_full;
  assign wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q[DEPTH_LOG2-1:0]]   <= req_op_i;
      fifo_idx_q[wr_ptr_q[DEPTH_LOG2-1:0]]  <= req_index_i;
      fifo_data_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= req_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    op_d       = op_q;
    idx_d      = idx_q;
    data_d     = data_q;
    rsp_op_d   = rsp_op_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          op_d     = fifo_op_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          idx_d    = fifo_idx_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          data_d   = fifo_data_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Writes and reserved ops produce no response.
        if (op_q == OP_READ || op_q == OP_SEARCH) state_d = ST_WAIT;
        else                                      state_d = ST_IDLE;
      end
      ST_WAIT: begin
        rsp_op_d = op_q;
        if (op_q == OP_READ) begin
          rsp_hit_d  = read_valid_i;
          rsp_data_d = read_value_i;
        end else begin
          rsp_hit_d  = search_valid_i;
          rsp_data_d = search_valid_i ? {{(DW-AW){1'b0}}, search_index_i} : '0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rsp_op_q   <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      rsp_op_q   <= rsp_op_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Cam interface: strobes and their index/data only live in ISSUE.
  assign read_o        = (state_q == ST_ISSUE) && (op_q == OP_READ);
  assign write_o       = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
  assign search_o      = (state_q == ST_ISSUE) && (op_q == OP_SEARCH);
  assign read_index_o  = read_o   ? idx_q  : '0;
  assign write_index_o = write_o  ? idx_q  : '0;
  assign write_data_o  = write_o  ? data_q : '0;
  assign search_data_o = search_o ? data_q : '0;

  // Response channel: registers are stable throughout RESP, zero otherwise.
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_op_o    = rsp_valid_o ? rsp_op_q   : '0;
  assign rsp_hit_o   = rsp_valid_o && rsp_hit_q;
  assign rsp_data_o  = rsp_valid_o ? rsp_data_q : '0;

`ifdef CAM_REQ_STATS_EN
  logic [15:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (rsp_valid_o && rsp_ready_i) begin
      if (rsp_hit_q) begin
        if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
      end else begin
        if (misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
`else
  assign stat_hits_o   = '0;
  assign stat_misses_o = '0;
`endif

endmodule

// File: tb/tb_cam_req_queue.sv
// -----------------------------------------------------------------------------
// tb_cam_req_queue
//   Directed bench for cam_req_queue. A small behavioural cam (one-cycle
//   latency, first-match search) answers the strobes. Every check is an
//   immediate assertion against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_cam_req_queue;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = 2'b00;
  logic [AW-1:0] req_index_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          read_o, write_o, search_o;
  logic [AW-1:0] read_index_o, write_index_o;
  logic [DW-1:0] write_data_o, search_data_o;
  logic          read_valid_i = 1'b0;
  logic          search_valid_i = 1'b0;
  logic [DW-1:0] read_value_i = '0;
  logic [AW-1:0] search_index_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [1:0]    rsp_op_o;
  logic          rsp_hit_o;
  logic [DW-1:0] rsp_data_o;
  logic [15:0]   stat_hits_o, stat_misses_o;

  int n_tests = 0;
  int n_fail  = 0;

  // strobe / response monitors
  int n_rd = 0, n_wr = 0, n_sr = 0, n_multi = 0, n_rsp_cyc = 0;

  cam_req_queue #(.ARRAY_WIDTH_LOG2(AW), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .read_o(read_o), .write_o(write_o), .search_o(search_o),
    .read_index_o(read_index_o), .write_index_o(write_index_o),
    .write_data_o(write_data_o), .search_data_o(search_data_o),
    .read_valid_i(read_valid_i), .search_valid_i(search_valid_i),
    .read_value_i(read_value_i), .search_index_i(search_index_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
    .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o),
    .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
  );

  always #5 clk = ~clk;

  // Behavioural cam: 32 x 32-bit, results valid the cycle after the strobe.
  logic [DW-1:0] cam_mem [32];
  logic          cam_match;
  logic [AW-1:0] cam_match_idx;

  initial for (int i = 0; i < 32; i++) cam_mem[i] = '0;

  always_comb begin
    cam_match     = 1'b0;
    cam_match_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cam_mem[i] == search_data_o) begin
        cam_match     = 1'b1;
        cam_match_idx = AW'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (write_o) cam_mem[write_index_o] <= write_data_o;
    read_valid_i   <= read_o;
    read_value_i   <= read_o ? cam_mem[read_index_o] : '0;
    search_valid_i <= search_o && cam_match;
    search_index_i <= (search_o && cam_match) ? cam_match_idx : '0;
    if (read_o)   n_rd <= n_rd + 1;
    if (write_o)  n_wr <= n_wr + 1;
    if (search_o) n_sr <= n_sr + 1;
    if (!$onehot0({read_o, write_o, search_o})) n_multi <= n_multi + 1;
    if (rsp_valid_o) n_rsp_cyc <= n_rsp_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] idx, input logic [DW-1:0] data);
    int budget = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_index_i = idx;
    req_data_i  = data;
    while (!req_ready_o && budget < 50) begin
      tick();
      budget++;
    end
    check("push_ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int budget = 0;
    while (!rsp_valid_o && budget < 50) begin
      tick();
      budget++;
    end
    check("rsp_valid", 32'(rsp_valid_o), 32'd1);
  endtask

  task automatic ack();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  logic [1:0]  exp_op   [5];
  logic [31:0] exp_data [5];
  int snap_rd, snap_wr, snap_sr, snap_rsp;

  initial begin
    // ---------------- reset
    tick(); tick(); tick();
    reset_i = 1'b0;
    check("rst_ready",   32'(req_ready_o), 32'd1);
    check("rst_rsp_vld", 32'(rsp_valid_o), 32'd0);
    check("rst_strobes", 32'({read_o, write_o, search_o}), 32'd0);
    check("rst_rsp_dat", rsp_data_o, 32'd0);
    check("rst_wdata",   write_data_o, 32'd0);

    // ---------------- write idx 1 = 1, then read idx 1
    push(2'b01, 5'd1, 32'h1);
    tick();
    check("wr_strobe", 32'(write_o), 32'd1);
    check("wr_index",  32'(write_index_o), 32'd1);
    check("wr_data",   write_data_o, 32'h1);
    check("wr_no_rd",  32'(read_o), 32'd0);
    tick();
    check("wr_pulse_end", 32'(write_o), 32'd0);
    push(2'b00, 5'd1, 32'h0);
    tick();
    check("rd_strobe", 32'(read_o), 32'd1);
    check("rd_index",  32'(read_index_o), 32'd1);
    tick();
    check("wait_no_strobe", 32'({read_o, write_o, search_o}), 32'd0);
    check("wait_no_rsp",    32'(rsp_valid_o), 32'd0);
    tick();
    check("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("rd_rsp_op",    32'(rsp_op_o), 32'd0);
    check("rd_rsp_hit",   32'(rsp_hit_o), 32'd1);
    check("rd_rsp_data",  rsp_data_o, 32'h1);
    ack();
    check("rd_rsp_done",  32'(rsp_valid_o), 32'd0);
    check("wr_count",     32'(n_wr), 32'd1);

    // ---------------- search hit / miss
    push(2'b01, 5'd5, 32'h5);
    push(2'b10, 5'd0, 32'h5);
    wait_rsp();
    check("srch_hit_op",   32'(rsp_op_o), 32'd2);
    check("srch_hit_hit",  32'(rsp_hit_o), 32'd1);
    check("srch_hit_data", rsp_data_o, 32'h5);
    ack();
    push(2'b10, 5'd0, 32'h9);
    wait_rsp();
    check("srch_miss_op",   32'(rsp_op_o), 32'd2);
    check("srch_miss_hit",  32'(rsp_hit_o), 32'd0);
    check("srch_miss_data", rsp_data_o, 32'h0);
    ack();

    // ---------------- fill FIFO behind a held response
    push(2'b01, 5'd2, 32'h22);
    push(2'b01, 5'd3, 32'h33);
    push(2'b11, 5'd7, 32'hDEAD);   // reserved op: dropped without strobe
    for (int i = 0; i < 6; i++) tick();
    check("wr_count2", 32'(n_wr), 32'd4);
    push(2'b00, 5'd1, 32'h0);
    wait_rsp();
    push(2'b00, 5'd2, 32'h0);
    push(2'b00, 5'd3, 32'h0);
    push(2'b00, 5'd5, 32'h0);
    check("ready_before_4th", 32'(req_ready_o), 32'd1);
    push(2'b10, 5'd0, 32'h33);
    check("full_ready_low", 32'(req_ready_o), 32'd0);
    snap_rd = n_rd; snap_wr = n_wr; snap_sr = n_sr;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid_o), 32'd1);
      check("hold_data",  rsp_data_o, 32'h1);
      check("hold_full",  32'(req_ready_o), 32'd0);
    end
    check("hold_no_rd", 32'(n_rd), 32'(snap_rd));
    check("hold_no_sr", 32'(n_sr + n_wr), 32'(snap_sr + snap_wr));

    exp_op[0] = 2'b00; exp_data[0] = 32'h1;
    exp_op[1] = 2'b00; exp_data[1] = 32'h22;
    exp_op[2] = 2'b00; exp_data[2] = 32'h33;
    exp_op[3] = 2'b00; exp_data[3] = 32'h5;
    exp_op[4] = 2'b10; exp_data[4] = 32'h3;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp();
      check($sformatf("drain%0d_op", k),   32'(rsp_op_o), 32'(exp_op[k]));
      check($sformatf("drain%0d_hit", k),  32'(rsp_hit_o), 32'd1);
      check($sformatf("drain%0d_data", k), rsp_data_o, exp_data[k]);
      tick();
    end
    rsp_ready_i = 1'b0;
    check("drain_ready", 32'(req_ready_o), 32'd1);
    check("drain_idle",  32'(rsp_valid_o), 32'd0);

    // ---------------- reset while in WAIT with 2 queued entries
    push(2'b00, 5'd2, 32'h0);
    push(2'b00, 5'd3, 32'h0);
    check("pre_rst_issue", 32'(read_o), 32'd1);
    push(2'b00, 5'd5, 32'h0);
    check("pre_rst_wait", 32'(read_o), 32'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_rsp",   32'(rsp_valid_o), 32'd0);
    check("mid_rst_ready", 32'(req_ready_o), 32'd1);
    snap_rd = n_rd; snap_rsp = n_rsp_cyc;
    for (int i = 0; i < 10; i++) tick();
    check("mid_rst_no_rd",  32'(n_rd), 32'(snap_rd));
    check("mid_rst_no_rsp", 32'(n_rsp_cyc), 32'(snap_rsp));
    check("mid_rst_stat_h", 32'(stat_hits_o), 32'd0);

    // ---------------- statistics: 3 hits, 2 misses
    push(2'b10, 5'd0, 32'h1);  wait_rsp(); check("st_h1", 32'(rsp_hit_o), 32'd1); ack();
    push(2'b10, 5'd0, 32'h9);  wait_rsp(); check("st_m1", 32'(rsp_hit_o), 32'd0); ack();
    push(2'b10, 5'd0, 32'h22); wait_rsp(); check("st_h2", 32'(rsp_data_o), 32'd2); ack();
    push(2'b10, 5'd0, 32'h77); wait_rsp(); check("st_m2", 32'(rsp_hit_o), 32'd0); ack();
    push(2'b10, 5'd0, 32'h5);  wait_rsp(); check("st_h3", 32'(rsp_data_o), 32'd5); ack();
`ifdef CAM_REQ_STATS_EN
    check("stat_hits",   32'(stat_hits_o),   32'd3);
    check("stat_misses", 32'(stat_misses_o), 32'd2);
`else
    check("stat_hits",   32'(stat_hits_o),   32'd0);
    check("stat_misses", 32'(stat_misses_o), 32'd0);
`endif
    check("one_hot_strobes", 32'(n_multi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_req_queue.md
Name: cam_req_queue

Overview:
- Front-end stage directly upstream of the cam block.
- Buffers read/write/search requests from a valid/ready client in a small FIFO.
- Issues one request at a time to the cam strobe ports, captures the cam result, and returns it on a valid/ready response channel.
- Serialises all traffic so the cam never sees simultaneous read/write/search strobes.

Parameters:
ARRAY_WIDTH_LOG2, 5, cam index width; data width is 2**ARRAY_WIDTH_LOG2 (matches cam)
DEPTH_LOG2, 2, request FIFO depth is 2**DEPTH_LOG2 entries

Ports:
clk  in  1  clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  1  client request valid
req_ready_o  out  1  FIFO can accept (= not full)
req_op_i  in  2  00 read, 01 write, 10 search, 11 reserved
req_index_i  in  ARRAY_WIDTH_LOG2  read/write index
req_data_i  in  2**ARRAY_WIDTH_LOG2  write data / search key
read_o, write_o, search_o  out  1 each  cam strobes, one-hot or zero
read_index_o, write_index_o  out  ARRAY_WIDTH_LOG2  cam indices
write_data_o, search_data_o  out  2**ARRAY_WIDTH_LOG2  cam data
read_valid_i, search_valid_i  in  1 each  cam result valid
read_value_i  in  2**ARRAY_WIDTH_LOG2  cam read data
search_index_i  in  ARRAY_WIDTH_LOG2  cam match index
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  client accepts response
rsp_op_o  out  2  op of the response (00 or 10)
rsp_hit_o  out  1  captured read_valid_i / search_valid_i
rsp_data_o  out  2**ARRAY_WIDTH_LOG2  read value, or zero-extended search index
stat_hits_o, stat_misses_o  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset: FIFO empty, FSM in IDLE, all strobes 0, rsp_valid_o 0, all data outputs 0, req_ready_o 1 from the first cycle after reset. Reset mid-operation flushes queued and in-flight requests with no response.
- FIFO:
  - Push when req_valid_i && req_ready_o.
  - req_ready_o = !full, registered-flag based; there is no same-cycle bypass when full even if a pop occurs.
  - Read and write pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - Push while empty: the entry becomes visible to the FSM the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head into the op register and go to ISSUE.
  - ISSUE: assert exactly one strobe for one cycle, with index/data driven from the op register.
    - Write: go to IDLE, no response.
    - Read or search: go to WAIT.
    - Op 11: no strobe, go to IDLE, silently dropped.
  - WAIT: the cam result is valid in this cycle (cam latency one cycle after strobe). Capture read_valid_i/read_value_i or search_valid_i/search_index_i into the response registers and go to RESP.
  - RESP: rsp_valid_o=1. Outputs are held stable until rsp_ready_i=1, then go to IDLE.
- Ordering: strictly FIFO order.
- Latency: minimum 4 cycles from accepted request to rsp_valid_o with an empty queue. Throughput is at most one request per 2 cycles (write) or 4 cycles (read/search).
- Strobes are 0 in every state except ISSUE. Index/data outputs are 0 when not in ISSUE.
- rsp_data_o for search: search_index_i in the low ARRAY_WIDTH_LOG2 bits, upper bits 0. On a miss, rsp_hit_o=0 and rsp_data_o=0.

Optional Feature:
- Macro: CAM_REQ_STATS_EN.
- Defined:
  - stat_hits_o and stat_misses_o count read/search responses by rsp_hit_o.
  - They increment on the RESP handshake cycle and saturate at 16'hFFFF.
  - Cleared by reset_i.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- Reset, then write idx 1 data 32'h1, then read idx 1 -> one write_o pulse with write_index_o=1; then read_o pulse; response rsp_op_o=00, rsp_hit_o=1, rsp_data_o=32'h1.
- Write idx 5 data 32'h5, then search key 32'h5 -> rsp_op_o=10, rsp_hit_o=1, rsp_data_o=32'h5; search key 32'h9 -> rsp_hit_o=0, rsp_data_o=0.
- Push 4 requests back-to-back while rsp_ready_i=0 -> req_ready_o falls after the 4th push. Response 1 is held stable. Raising rsp_ready_i drains all responses in issue order.
- Hold rsp_ready_i low 10 cycles during RESP -> rsp_valid_o and rsp_data_o are unchanged every cycle and no strobes are issued.
- Assert reset_i while in WAIT with 2 queued entries -> next cycle: rsp_valid_o=0, req_ready_o=1, no further strobes, no response emitted.
- With CAM_REQ_STATS_EN defined: 3 search hits and 2 misses -> stat_hits_o=3, stat_misses_o=2. Without the macro, both read 0.
